sidechannel_activity_monitor: RTL and testbench

Defensive monitor placed directly downstream of the crypto-datapath activity nets, including the side-channel amplifier node.
- Counts bit toggles on a monitored vector over a fixed window that opens on each encryption start.
- Compares the count against a programmable threshold.
- Raises a one-cycle alarm pulse and a sticky alarm flag when the toggle activity is anomalous.
- Feeds the security alert aggregator.

---
 rtl/sidechannel_mon_pkg.sv | 28 ++
 rtl/toggle_popcount.sv | 26 ++
 rtl/sidechannel_activity_monitor.sv | 133 +++++++++++++
 tb/tb_sidechannel_activity_monitor.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sidechannel_mon_pkg.sv
// Purpose : shared types, default sizes and popcount helper for activity monitors.
// Latency : n/a (package).
// Backpressure: n/a (package).
package sidechannel_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        EVAL  = 2'd2
    } mon_state_e;

    localparam int MON_WIDTH      = 8;
    localparam int MON_WIN_CYCLES = 64;
    localparam int MON_CNT_W      = 16;

    // Widest vector the popcount helper accepts; callers zero-extend.
    localparam int POP_MAX_W      = 256;

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            if (v[i]) cnt++;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/toggle_popcount.sv
// Purpose : number of bits that differ between the current and previous sample.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   i_cur  [WIDTH]               current sample
//   i_prev [WIDTH]               previous sample
//   o_cnt  [$clog2(WIDTH+1)]     popcount(i_cur ^ i_prev)
module toggle_popcount
    import sidechannel_mon_pkg::*;
#(
    parameter int WIDTH = MON_WIDTH
) (
    input  logic [WIDTH-1:0]           i_cur,
    input  logic [WIDTH-1:0]           i_prev,
    output logic [$clog2(WIDTH+1)-1:0] o_cnt
);

    localparam int POP_W = $clog2(WIDTH + 1);

    logic [POP_MAX_W-1:0] w_diff_ext;

    assign w_diff_ext = POP_MAX_W'(i_cur ^ i_prev);
    assign o_cnt      = POP_W'(popcount(w_diff_ext));

endmodule

// File: rtl/sidechannel_activity_monitor.sv
// Purpose : counts toggles on mon_i over a WIN_CYCLES window and flags counts above threshold.
// Latency : count_valid_o / alarm_o appear WIN_CYCLES+2 cycles after window_start_i.
// Backpressure: none; starts while busy are dropped, enable_i low aborts the window.
//
// Ports:
//   clk, rst_n (async, active-low)
//   enable_i, window_start_i, mon_i[WIDTH], threshold_i[CNT_W], clear_i
//   busy_o, toggle_count_o[CNT_W], count_valid_o, alarm_o, alarm_sticky_o
module sidechannel_activity_monitor
    import sidechannel_mon_pkg::*;
#(
    parameter int WIDTH      = MON_WIDTH,
    parameter int WIN_CYCLES = MON_WIN_CYCLES,
    parameter int CNT_W      = MON_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             window_start_i,
    input  logic [WIDTH-1:0] mon_i,
    input  logic [CNT_W-1:0] threshold_i,
    input  logic             clear_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] toggle_count_o,
    output logic             count_valid_o,
    output logic             alarm_o,
    output logic             alarm_sticky_o
);

    localparam int POP_W = $clog2(WIDTH + 1);
    localparam int CYC_W = $clog2(WIN_CYCLES);

    mon_state_e       r_state;
    mon_state_e       w_next_state;

    logic [WIDTH-1:0] r_prev;
    logic [CNT_W-1:0] r_thr;
    logic [CNT_W-1:0] r_acc;
    logic [CYC_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_count;
    logic             r_count_valid;
    logic             r_alarm;
    logic             r_sticky;

    logic [POP_W-1:0] w_pop;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_acc_next;
    logic             w_start;
    logic             w_counting;
    logic             w_eval_fire;
    logic             w_alarm_set;
    logic             w_busy;

    toggle_popcount #(
        .WIDTH (WIDTH)
    ) u_pop (
        .i_cur  (mon_i),
        .i_prev (r_prev),
        .o_cnt  (w_pop)
    );

    // Extra carry bit detects overflow; clamp instead of wrapping.
    assign w_sum      = {1'b0, r_acc} + (CNT_W + 1)'(w_pop);
    assign w_acc_next = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (enable_i && window_start_i) w_next_state = COUNT;
            COUNT:   if (!enable_i)                  w_next_state = IDLE;
                     else if (r_cyc == '0)           w_next_state = EVAL;
            EVAL:                                    w_next_state = IDLE;
            default:                                 w_next_state = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_start     = (r_state == IDLE) && enable_i && window_start_i;
        w_counting  = (r_state == COUNT);
        w_busy      = (r_state == COUNT) || (r_state == EVAL);
        // Dropping enable during EVAL also suppresses the result.
        w_eval_fire = (r_state == EVAL) && enable_i;
        w_alarm_set = w_eval_fire && (r_acc > r_thr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev        <= '0;
            r_thr         <= '0;
            r_acc         <= '0;
            r_cyc         <= '0;
            r_count       <= '0;
            r_count_valid <= 1'b0;
            r_alarm       <= 1'b0;
            r_sticky      <= 1'b0;
        end else begin
            // Sampled every cycle so the first COUNT cycle sees the start-cycle value.
            r_prev <= mon_i;

            if (w_start) begin
                r_thr <= threshold_i;
                r_acc <= '0;
                r_cyc <= CYC_W'(WIN_CYCLES - 1);
            end else if (w_counting) begin
                r_acc <= w_acc_next;
                r_cyc <= r_cyc - 1'b1;
            end

            if (w_eval_fire) r_count <= r_acc;
            r_count_valid <= w_eval_fire;
            r_alarm       <= w_alarm_set;

            // Sticky rises with the alarm pulse; holding r_alarm in the set term
            // lets an alarm win over a clear issued in the pulse cycle.
            r_sticky <= (r_sticky & ~clear_i) | w_alarm_set | r_alarm;
        end
    end

    assign busy_o         = w_busy;
    assign toggle_count_o = r_count;
    assign count_valid_o  = r_count_valid;
    assign alarm_o        = r_alarm;
    assign alarm_sticky_o = r_sticky;

endmodule

// File: tb/tb_sidechannel_activity_monitor.sv
module tb_sidechannel_activity_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_i = 1'b0;
    logic        window_start_i = 1'b0;
    logic [7:0]  mon_i = 8'h00;
    logic [15:0] thr16 = 16'h0;
    logic [7:0]  thr8;
    logic        clear_i = 1'b0;

    logic        busy16, valid16, alarm16, sticky16;
    logic [15:0] count16;
    logic        busy8, valid8, alarm8, sticky8;
    logic [7:0]  count8;

    assign thr8 = thr16[7:0];

    always #5 clk = ~clk;

    sidechannel_activity_monitor #(.WIDTH(8), .WIN_CYCLES(64), .CNT_W(16)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_i       (enable_i),
        .window_start_i (window_start_i),
        .mon_i          (mon_i),
        .threshold_i    (thr16),
        .clear_i        (clear_i),
        .busy_o         (busy16),
        .toggle_count_o (count16),
        .count_valid_o  (valid16),
        .alarm_o        (alarm16),
        .alarm_sticky_o (sticky16)
    );

    sidechannel_activity_monitor #(.WIDTH(8), .WIN_CYCLES(64), .CNT_W(8)) u_dut8 (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_i       (enable_i),
        .window_start_i (window_start_i),
        .mon_i          (mon_i),
        .threshold_i    (thr8),
        .clear_i        (clear_i),
        .busy_o         (busy8),
        .toggle_count_o (count8),
        .count_valid_o  (valid8),
        .alarm_o        (alarm8),
        .alarm_sticky_o (sticky8)
    );

    int nvec = 0;
    int nerr = 0;

    // Results captured by run_window; index = cycle number relative to the start cycle (0).
    int          nvalid;
    int          vcyc;
    logic [15:0] vcount16;
    logic [7:0]  vcount8;
    logic        valarm16;
    logic        valarm8;
    logic        busy_hist   [0:127];
    logic        alarm_hist  [0:127];
    logic        sticky_hist [0:127];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 0: quiet, 1: bit0 toggles every cycle, 2: bit0 toggles every 2nd cycle, 3: all bits every cycle
    function automatic logic [7:0] pat(input int mode, input int c);
        int cc;
        cc = c;
        case (mode)
            1:       return {7'b0, cc[0]};
            2:       return {7'b0, cc[1]};
            3:       return cc[0] ? 8'hFF : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic run_window(input int mode, input logic [15:0] thr, input int abort_at,
                              input int restart_at, input int clr_at, input int ncyc);
        nvalid = 0;
        vcyc   = -1;
        enable_i       = 1'b1;
        window_start_i = 1'b1;
        thr16          = thr;
        mon_i          = pat(mode, 0);
        step();
        busy_hist[1] = busy16;
        for (int c = 1; c <= ncyc; c++) begin
            window_start_i = (c == restart_at);
            if (c == abort_at) enable_i = 1'b0;
            clear_i = (c == clr_at) || (c == clr_at + 1);
            mon_i   = pat(mode, c);
            step();
            busy_hist[c+1]   = busy16;
            alarm_hist[c+1]  = alarm16;
            sticky_hist[c+1] = sticky16;
            if (valid16) begin
                nvalid++;
                if (vcyc < 0) begin
                    vcyc     = c + 1;
                    vcount16 = count16;
                    vcount8  = count8;
                    valarm16 = alarm16;
                    valarm8  = alarm8;
                end
            end
        end
        window_start_i = 1'b0;
        enable_i       = 1'b1;
        clear_i        = 1'b0;
    endtask

    task automatic clear_pulse();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_busy",   busy16,   0);
        chk("rst_count",  count16,  0);
        chk("rst_valid",  valid16,  0);
        chk("rst_alarm",  alarm16,  0);
        chk("rst_sticky", sticky16, 0);
        step();
        rst_n = 1'b1;
        step();

        // Start without enable is ignored
        window_start_i = 1'b1;
        enable_i       = 1'b0;
        step();
        window_start_i = 1'b0;
        step();
        chk("start_no_enable_busy", busy16, 0);

        // 1: quiet bus
        run_window(0, 16'd32, -1, -1, -1, 70);
        chk("t1_busy_open",   busy_hist[1], 1);
        chk("t1_busy_eval",   busy_hist[65], 1);
        chk("t1_busy_done",   busy_hist[66], 0);
        chk("t1_nvalid",      nvalid, 1);
        chk("t1_valid_cycle", vcyc, 66);
        chk("t1_count",       vcount16, 0);
        chk("t1_alarm",       valarm16, 0);
        chk("t1_sticky",      sticky16, 0);

        // 2: bit0 toggling every cycle
        run_window(1, 16'd32, -1, -1, -1, 70);
        chk("t2_valid_cycle", vcyc, 66);
        chk("t2_count",       vcount16, 64);
        chk("t2_alarm",       valarm16, 1);
        chk("t2_alarm_width", alarm_hist[67], 0);
        chk("t2_sticky_hold", sticky_hist[70], 1);
        clear_pulse();
        chk("t2_sticky_clr",  sticky16, 0);

        // 3: 32 toggles, equality vs threshold-1
        run_window(2, 16'd32, -1, -1, -1, 70);
        chk("t3_count_eq",    vcount16, 32);
        chk("t3_alarm_eq",    valarm16, 0);
        chk("t3_sticky_eq",   sticky16, 0);
        run_window(2, 16'd31, -1, -1, -1, 70);
        chk("t3_count_lt",    vcount16, 32);
        chk("t3_alarm_lt",    valarm16, 1);
        clear_pulse();

        // 4: 512 toggles, 8-bit counter saturates
        run_window(3, 16'd200, -1, -1, -1, 70);
        chk("t4_count8_sat",  vcount8, 8'hFF);
        chk("t4_alarm8",      valarm8, 1);
        chk("t4_count16",     vcount16, 512);
        chk("t4_alarm16",     valarm16, 1);
        clear_pulse();

        // 5: abort at cycle 20, then ignored restart mid-window
        run_window(1, 16'd0, 20, -1, -1, 80);
        chk("t5_abort_nvalid", nvalid, 0);
        chk("t5_abort_busy20", busy_hist[20], 1);
        chk("t5_abort_busy21", busy_hist[21], 0);
        chk("t5_abort_hold",   count16, 512);
        chk("t5_abort_sticky", sticky16, 0);
        run_window(0, 16'd1000, -1, 30, -1, 100);
        chk("t5_restart_nvalid", nvalid, 1);
        chk("t5_restart_cycle",  vcyc, 66);
        chk("t5_restart_count",  vcount16, 0);

        // 6: clear coincident with alarm, then clear alone
        run_window(1, 16'd10, -1, -1, 66, 70);
        chk("t6_alarm_pulse",     alarm_hist[66], 1);
        chk("t6_set_wins",        sticky_hist[67], 1);
        chk("t6_clear_alone",     sticky_hist[68], 0);

        // Async reset mid-window
        enable_i       = 1'b1;
        window_start_i = 1'b1;
        thr16          = 16'd5;
        step();
        window_start_i = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            mon_i = pat(1, c);
            step();
        end
        chk("rst_mid_busy_before", busy16, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy",   busy16,  0);
        chk("rst_mid_count",  count16, 0);
        chk("rst_mid_valid",  valid16, 0);
        chk("rst_mid_alarm",  alarm16, 0);
        chk("rst_mid_sticky", sticky16, 0);
        step();
        rst_n = 1'b1;
        step();

        // Normal operation after reset
        run_window(1, 16'd32, -1, -1, -1, 70);
        chk("post_rst_cycle", vcyc, 66);
        chk("post_rst_count", vcount16, 64);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
